// File: rtl/wb_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_dec_pkg
// Description : Shared types and constants for the wishbone slave decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_dec_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_DONE = ST_DONE
    } state_t;

    localparam logic [31:0] DEAD_DATA_DEFAULT = 32'hDEADBEEF;
    localparam int          SEL_BIT           = 13;
    localparam int          SADR_W            = SEL_BIT;

    // Latched copy of one master request, as presented to a slave
    typedef struct packed {
        logic              we;
        logic [SADR_W-1:0] adr;
        logic [31:0]       dat;
        logic [3:0]        sel;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_watchdog
// Description : Loadable down-counter for stalled cycles plus a sticky flag
//               and saturating 8-bit count of expiry events.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    input  logic       expire,
    input  logic       clr,
    output logic       expired,
    output logic       timeout_flag,
    output logic [7:0] timeout_cnt
);

    localparam logic [7:0] c_load_value = 8'(TIMEOUT - 1);

    logic [7:0] r_wd;
    logic       r_flag;
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= 8'd0;
        end else if (load) begin
            r_wd <= c_load_value;
        end else if (dec && (r_wd != 8'd0)) begin
            r_wd <= r_wd - 8'd1;
        end
    end

    // Clear takes priority over an expiry landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_cnt  <= 8'd0;
        end else if (clr) begin
            r_flag <= 1'b0;
            r_cnt  <= 8'd0;
        end else if (expire) begin
            r_flag <= 1'b1;
            if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign expired      = (r_wd == 8'd0);
    assign timeout_flag = r_flag;
    assign timeout_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/wb_slave_decoder.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_decoder
// Description : Registered two-way wishbone decoder (USB CSRs / EP RAM) with a
//               watchdog that force-completes stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_decoder
    import wb_dec_pkg::*;
#(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] DEAD_DATA = DEAD_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_CYC,
    input  logic        m_STB,
    input  logic        m_WE,
    input  logic [13:0] m_ADR,
    input  logic [31:0] m_DAT_MOSI,
    input  logic [3:0]  m_SEL,
    output logic        m_ACK,
    output logic [31:0] m_DAT_MISO,
    output logic        s0_CYC,
    output logic        s0_STB,
    output logic        s0_WE,
    output logic [12:0] s0_ADR,
    output logic [31:0] s0_DAT_MOSI,
    output logic [3:0]  s0_SEL,
    input  logic        s0_ACK,
    input  logic [31:0] s0_DAT_MISO,
    output logic        s1_CYC,
    output logic        s1_STB,
    output logic        s1_WE,
    output logic [12:0] s1_ADR,
    output logic [31:0] s1_DAT_MOSI,
    output logic [3:0]  s1_SEL,
    input  logic        s1_ACK,
    input  logic [31:0] s1_DAT_MISO,
    input  logic        timeout_clr,
    output logic        timeout_flag,
    output logic [7:0]  timeout_cnt
);

    state_t      r_state;
    state_t      w_next;
    logic        r_sel;
    logic        r_we;
    req_t        r_s0_req;
    req_t        r_s1_req;
    logic        r_s0_act;
    logic        r_s1_act;
    logic [31:0] r_miso;

    req_t        w_req;
    logic        w_req_sel;
    logic        w_start;
    logic        w_drop;
    logic        w_ack_hit;
    logic        w_expire;
    logic        w_dec;
    logic        w_wd_zero;
    logic        w_sel_ack;
    logic [31:0] w_sel_dat;

    assign w_req     = '{we: m_WE, adr: m_ADR[SADR_W-1:0], dat: m_DAT_MOSI, sel: m_SEL};
    assign w_req_sel = m_ADR[SEL_BIT];

    // Only the slave latched for this cycle may complete it
    assign w_sel_ack = r_sel ? s1_ACK      : s0_ACK;
    assign w_sel_dat = r_sel ? s1_DAT_MISO : s0_DAT_MISO;

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_drop    = 1'b0;
        w_ack_hit = 1'b0;
        w_expire  = 1'b0;
        w_dec     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m_CYC && m_STB) begin
                    w_start = 1'b1;
                    w_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!m_CYC) begin
                    w_drop = 1'b1;
                    w_next = S_IDLE;
                end else if (w_sel_ack) begin
                    w_ack_hit = 1'b1;
                    w_drop    = 1'b1;
                    w_next    = S_DONE;
                end else if (w_wd_zero) begin
                    w_expire = 1'b1;
                    w_drop   = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The unselected slave is zeroed so it never sees stale request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= 1'b0;
            r_we     <= 1'b0;
            r_s0_req <= '0;
            r_s1_req <= '0;
            r_s0_act <= 1'b0;
            r_s1_act <= 1'b0;
        end else if (w_start) begin
            r_sel    <= w_req_sel;
            r_we     <= m_WE;
            r_s0_req <= w_req_sel ? '0 : w_req;
            r_s1_req <= w_req_sel ? w_req : '0;
            r_s0_act <= !w_req_sel;
            r_s1_act <= w_req_sel;
        end else if (w_drop) begin
            r_s0_act <= 1'b0;
            r_s1_act <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso <= 32'd0;
        end else if (!r_we) begin
            if (w_ack_hit) begin
                r_miso <= w_sel_dat;
            end else if (w_expire) begin
                r_miso <= DEAD_DATA;
            end
        end
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (w_start),
        .dec          (w_dec),
        .expire       (w_expire),
        .clr          (timeout_clr),
        .expired      (w_wd_zero),
        .timeout_flag (timeout_flag),
        .timeout_cnt  (timeout_cnt)
    );

    assign m_ACK       = (r_state == S_DONE);
    assign m_DAT_MISO  = r_miso;

    assign s0_CYC      = r_s0_act;
    assign s0_STB      = r_s0_act;
    assign s0_WE       = r_s0_req.we;
    assign s0_ADR      = r_s0_req.adr;
    assign s0_DAT_MOSI = r_s0_req.dat;
    assign s0_SEL      = r_s0_req.sel;

    assign s1_CYC      = r_s1_act;
    assign s1_STB      = r_s1_act;
    assign s1_WE       = r_s1_req.we;
    assign s1_ADR      = r_s1_req.adr;
    assign s1_DAT_MOSI = r_s1_req.dat;
    assign s1_SEL      = r_s1_req.sel;

endmodule
`default_nettype wire
